// File: rtl/dac_write_scheduler.sv
// Round-robin scheduler sharing one SPI DAC serializer between channels.
// Latches per-channel codes, issues 16-bit commands, strobes ldac_n.
module dac_write_scheduler #(
  parameter int         NUM_CH      = 2,
  parameter logic [1:0] CFG_BITS    = 2'b11,
  parameter int         TIMEOUT_CYC = 64,
  parameter int         LDAC_CYC    = 2,
  parameter int         GAP_CYC     = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_CH-1:0]    wr_en,
  input  logic [NUM_CH*12-1:0] wr_data,
  input  logic                 clr_status,
  input  logic                 spi_busy,
  input  logic                 spi_done,
  output logic                 spi_start,
  output logic [15:0]          spi_word,
  output logic                 ldac_n,
  output logic [NUM_CH-1:0]    pending,
  output logic [NUM_CH-1:0]    overwrite,
  output logic                 timeout_err,
  output logic                 busy
);

  typedef enum logic [2:0] {
    IDLE, START, WAIT, LDAC, GAP
  } state_t;

  state_t            state;
  logic [15:0]       cnt;
  logic [1:0]        rr_ptr;
  logic [11:0]       shadow [NUM_CH];
  logic              grant;
  logic [1:0]        gnt_idx;
  logic [11:0]       gnt_code;
  logic [NUM_CH-1:0] gnt_oh;
  logic [NUM_CH-1:0] take;
  logic [1:0]        rr_next;

  function automatic int wrap(input int a);
    return (a >= NUM_CH) ? a - NUM_CH : a;
  endfunction

  // Lowest rotation offset from rr_ptr wins; it is assigned last.
  always_comb begin
    gnt_idx  = '0;
    gnt_code = '0;
    gnt_oh   = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (i == wrap(int'(rr_ptr) + k) && pending[i]) begin
          gnt_idx   = 2'(i);
          gnt_code  = shadow[i];
          gnt_oh    = '0;
          gnt_oh[i] = 1'b1;
        end
      end
    end
    grant   = (state == IDLE) && (|pending) && !spi_busy;
    take    = grant ? gnt_oh : '0;
    rr_next = (gnt_idx == 2'(NUM_CH - 1)) ? 2'd0 : gnt_idx + 2'd1;
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      rr_ptr      <= '0;
      spi_start   <= 1'b0;
      spi_word    <= '0;
      ldac_n      <= 1'b1;
      pending     <= '0;
      overwrite   <= '0;
      timeout_err <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) shadow[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++)
        if (wr_en[i]) shadow[i] <= wr_data[12*i +: 12];
      pending   <= (pending & ~take) | wr_en;
      overwrite <= (clr_status ? '0 : overwrite)
                 | (wr_en & pending & ~take);
      spi_start <= 1'b0;
      if (clr_status) timeout_err <= 1'b0;
      unique case (state)
        IDLE: begin
          if (grant) begin
            spi_word  <= {gnt_idx, CFG_BITS, gnt_code};
            rr_ptr    <= rr_next;
            spi_start <= 1'b1;
            state     <= START;
          end
        end
        START: begin
          cnt   <= '0;
          state <= WAIT;
        end
        WAIT: begin
          if (spi_done) begin
            cnt    <= '0;
            ldac_n <= 1'b0;
            state  <= LDAC;
          end else if (cnt == 16'(TIMEOUT_CYC - 1)) begin
            timeout_err <= 1'b1;
            cnt         <= '0;
            state       <= GAP;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        LDAC: begin
          if (cnt == 16'(LDAC_CYC - 1)) begin
            ldac_n <= 1'b1;
            cnt    <= '0;
            state  <= GAP;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        GAP: begin
          if (cnt == 16'(GAP_CYC - 1)) begin
            cnt   <= '0;
            state <= IDLE;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dac_write_scheduler.sv
// Scoreboard bench for dac_write_scheduler with a simple serializer model.
// Expected SPI words are queued at write time and popped on spi_start.
module tb_dac_write_scheduler;

  logic        clk;
  logic        reset;
  logic [1:0]  wr_en;
  logic [23:0] wr_data;
  logic        clr_status;
  logic        spi_busy;
  logic        spi_done;
  logic        spi_start;
  logic [15:0] spi_word;
  logic        ldac_n;
  logic [1:0]  pending;
  logic [1:0]  overwrite;
  logic        timeout_err;
  logic        busy;

  int          checks = 0;
  int          passed = 0;
  logic [15:0] exp_q[$];
  logic [15:0] mon_exp;
  bit          auto_done = 1'b1;
  int          ldac_lows = 0;

  dac_write_scheduler dut (
    .clk         (clk),
    .reset       (reset),
    .wr_en       (wr_en),
    .wr_data     (wr_data),
    .clr_status  (clr_status),
    .spi_busy    (spi_busy),
    .spi_done    (spi_done),
    .spi_start   (spi_start),
    .spi_word    (spi_word),
    .ldac_n      (ldac_n),
    .pending     (pending),
    .overwrite   (overwrite),
    .timeout_err (timeout_err),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Serializer model: done pulse 4 cycles after start unless withheld
  initial begin
    forever begin
      @(negedge clk);
      if (spi_start === 1'b1 && auto_done) begin
        repeat (4) @(negedge clk);
        spi_done = 1'b1;
        @(negedge clk);
        spi_done = 1'b0;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (spi_start === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL sb_word: got spi_word=%h, expected no transfer",
                   spi_word);
        end else begin
          mon_exp = exp_q.pop_front();
          if (spi_word !== mon_exp)
            $display("FAIL sb_word: got %h, expected %h", spi_word, mon_exp);
          else
            passed++;
        end
      end
    end
  end

  always @(negedge clk)
    if (ldac_n === 1'b0) ldac_lows++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic drive_wr(input logic [1:0] en,
                          input logic [11:0] d0,
                          input logic [11:0] d1);
    wr_en   = en;
    wr_data = {d1, d0};
    @(negedge clk);
    wr_en   = 2'b00;
  endtask

  task automatic wait_idle(input int bound, input string nm);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((busy !== 1'b0 || pending !== 2'b00) && n < bound);
    checks++;
    if (busy !== 1'b0 || pending !== 2'b00)
      $display("FAIL %s_idle: busy=%b pending=%b, expected 0/00 within %0d",
               nm, busy, pending, bound);
    else
      passed++;
  endtask

  task automatic wait_start(input int bound, input string nm);
    int n = 0;
    while (spi_start !== 1'b1 && n < bound) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (spi_start !== 1'b1)
      $display("FAIL %s_start: spi_start=%b, expected 1 within %0d",
               nm, spi_start, bound);
    else
      passed++;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({spi_start, ldac_n, busy} !== 3'b010)
      $display("FAIL rst_ctl: start/ldac_n/busy=%b, expected 010",
               {spi_start, ldac_n, busy});
    else passed++;
    checks++;
    if (spi_word !== 16'h0000)
      $display("FAIL rst_word: got %h, expected 0000", spi_word);
    else passed++;
    checks++;
    if ({pending, overwrite, timeout_err} !== 5'b0)
      $display("FAIL rst_status: pend/ovw/tmo=%b, expected 00000",
               {pending, overwrite, timeout_err});
    else passed++;
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single();
    ldac_lows = 0;
    exp_q.push_back(16'h3ABC);
    drive_wr(2'b01, 12'hABC, 12'h000);
    checks++;
    if (pending !== 2'b01 || spi_start !== 1'b0)
      $display("FAIL single_capture: pending=%b start=%b, expected 01/0",
               pending, spi_start);
    else passed++;
    @(negedge clk);
    checks++;
    if (spi_start !== 1'b1)
      $display("FAIL single_latency: spi_start=%b, expected 1", spi_start);
    else passed++;
    @(negedge clk);
    checks++;
    if (spi_start !== 1'b0 || spi_word !== 16'h3ABC)
      $display("FAIL single_hold: start=%b word=%h, expected 0/3abc",
               spi_start, spi_word);
    else passed++;
    wait_idle(100, "single");
    checks++;
    if (ldac_lows != 2)
      $display("FAIL single_ldac: low cycles=%0d, expected 2", ldac_lows);
    else passed++;
  endtask

  task automatic test_both();
    exp_q.push_back(16'h3111);
    exp_q.push_back(16'h7222);
    drive_wr(2'b11, 12'h111, 12'h222);
    wait_idle(200, "both1");
    exp_q.push_back(16'h3333);
    exp_q.push_back(16'h7444);
    drive_wr(2'b11, 12'h333, 12'h444);
    wait_idle(200, "both2");
  endtask

  task automatic test_overwrite();
    exp_q.push_back(16'h3555);
    exp_q.push_back(16'h7200);
    drive_wr(2'b01, 12'h555, 12'h000);
    wait_start(20, "ovw");
    wr_en   = 2'b10;
    wr_data = {12'h100, 12'h000};
    @(negedge clk);
    wr_data = {12'h200, 12'h000};
    @(negedge clk);
    wr_en   = 2'b00;
    checks++;
    if (overwrite !== 2'b10)
      $display("FAIL ovw_set: overwrite=%b, expected 10", overwrite);
    else passed++;
    wait_idle(200, "ovw");
    checks++;
    if (overwrite !== 2'b10)
      $display("FAIL ovw_sticky: overwrite=%b, expected 10", overwrite);
    else passed++;
    clr_status = 1'b1;
    @(negedge clk);
    clr_status = 1'b0;
    checks++;
    if (overwrite !== 2'b00)
      $display("FAIL ovw_clear: overwrite=%b, expected 00", overwrite);
    else passed++;
  endtask

  task automatic test_busy_coincide();
    int starts = 0;
    exp_q.push_back(16'h70AA);
    exp_q.push_back(16'h70BB);
    spi_busy = 1'b1;
    drive_wr(2'b10, 12'h000, 12'h0AA);
    repeat (8) begin
      if (spi_start === 1'b1) starts++;
      @(negedge clk);
    end
    checks++;
    if (starts != 0 || busy !== 1'b0 || pending !== 2'b10)
      $display("FAIL busy_hold: starts=%0d busy=%b pending=%b, expected 0/0/10",
               starts, busy, pending);
    else passed++;
    spi_busy = 1'b0;
    drive_wr(2'b10, 12'h000, 12'h0BB);
    checks++;
    if (spi_start !== 1'b1 || pending !== 2'b10 || overwrite !== 2'b00)
      $display("FAIL coincide: start=%b pend=%b ovw=%b, expected 1/10/00",
               spi_start, pending, overwrite);
    else passed++;
    wait_idle(200, "coincide");
  endtask

  task automatic test_timeout();
    int n = 0;
    ldac_lows = 0;
    auto_done = 1'b0;
    exp_q.push_back(16'h3321);
    exp_q.push_back(16'h7654);
    drive_wr(2'b11, 12'h321, 12'h654);
    wait_start(20, "tmo");
    do begin
      @(negedge clk);
      n++;
    end while (timeout_err !== 1'b1 && n < 200);
    auto_done = 1'b1;
    checks++;
    if (timeout_err !== 1'b1 || n != 65)
      $display("FAIL tmo_timing: err=%b after %0d cycles, expected 1 after 65",
               timeout_err, n);
    else passed++;
    wait_idle(200, "tmo");
    checks++;
    if (ldac_lows != 2)
      $display("FAIL tmo_ldac: low cycles=%0d, expected 2", ldac_lows);
    else passed++;
    checks++;
    if (timeout_err !== 1'b1)
      $display("FAIL tmo_sticky: timeout_err=%b, expected 1", timeout_err);
    else passed++;
    clr_status = 1'b1;
    @(negedge clk);
    clr_status = 1'b0;
    checks++;
    if (timeout_err !== 1'b0)
      $display("FAIL tmo_clear: timeout_err=%b, expected 0", timeout_err);
    else passed++;
  endtask

  task automatic test_reset_mid();
    int starts = 0;
    auto_done = 1'b0;
    exp_q.push_back(16'h3777);
    drive_wr(2'b01, 12'h777, 12'h000);
    wait_start(20, "rstmid");
    repeat (3) @(negedge clk);
    drive_wr(2'b10, 12'h000, 12'h999);
    reset = 1'b1;
    #1;
    checks++;
    if ({spi_start, spi_word, ldac_n, pending, overwrite, timeout_err, busy}
        !== {1'b0, 16'h0000, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0})
      $display("FAIL rstmid_out: start=%b word=%h ldac=%b pend=%b busy=%b, expected 0/0000/1/00/0",
               spi_start, spi_word, ldac_n, pending, busy);
    else passed++;
    @(negedge clk);
    reset = 1'b0;
    auto_done = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (spi_start === 1'b1) starts++;
    end
    checks++;
    if (starts != 0)
      $display("FAIL rstmid_drop: starts=%0d, expected 0", starts);
    else passed++;
  endtask

  initial begin
    reset      = 1'b1;
    wr_en      = 2'b00;
    wr_data    = '0;
    clr_status = 1'b0;
    spi_busy   = 1'b0;
    spi_done   = 1'b0;
    test_reset();
    test_single();
    apply_reset();
    test_both();
    test_overwrite();
    test_busy_coincide();
    test_timeout();
    test_reset_mid();
    checks++;
    if (exp_q.size() != 0)
      $display("FAIL sb_drain: %0d words left, expected 0", exp_q.size());
    else passed++;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
